if_fetch_buf: RTL

IF_FETCH_BUF -- requirements
Module: if_fetch_buf

---
 rtl/if_fetch_buf_if.sv | 22 ++
 rtl/if_fetch_buf.sv | 96 +++++++++
 2 files changed

// File: rtl/if_fetch_buf_if.sv
// rtl/if_fetch_buf_if.sv - instruction fetch request, response and output handshake bundle
interface if_fetch_buf_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_insn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_insn,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_insn, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_insn,
        output imem_req_ready, imem_rsp_valid, imem_rsp_insn, out_ready
    );
endinterface

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - credit-limited instruction prefetch buffer with redirect flush
module if_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          br_taken,
    input  logic [31:0]   br_addr,
    if_fetch_buf_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   insn_mem [DEPTH];

    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_live;
    logic        push;
    logic        pop;
    logic [31:0] br_target;
    logic        br_addr_unused;

    // Buffered plus in-flight entries never exceed DEPTH, so every push has a slot.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
    assign req_valid = reset & cpu_en & ~br_taken & credit_ok;
    assign req_fire  = req_valid & bus.imem_req_ready;
    assign rsp_live  = bus.imem_rsp_valid & (outstanding != '0);
    assign push      = rsp_live & ~br_taken & (drop_cnt == '0);
    assign pop       = (count != '0) & bus.out_ready & ~br_taken;
    assign br_target = {br_addr[31:2], 2'b00};
    assign br_addr_unused = ^br_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
            if (br_taken) begin
                // Everything still in flight belongs to the old path and is skipped on return.
                fetch_pc <= br_target;
                rsp_pc   <= br_target;
                drop_cnt <= outstanding - CW'(rsp_live);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_live && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            insn_mem[wr_ptr] <= bus.imem_rsp_insn;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = (count != '0);
    assign bus.out_pc         = pc_mem[rd_ptr];
    assign bus.out_insn       = insn_mem[rd_ptr];
endmodule
